// File: rtl/vx_dispatch_packet_arbiter_pkg.sv
// Shared types and helpers for the packetised dispatch arbiter.
// Holds the arbiter state encoding and the requester-index width helper.
package vx_dispatch_packet_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // A single requester still needs a 1-bit index field.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_packet_arbiter_if.sv
// Bundle of the per-requester dispatch streams and the shared FU-side beat port.
// master drives the requester side and out_ready; slave is the arbiter.
interface vx_dispatch_packet_arbiter_if
    import vx_dispatch_packet_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64
);
    localparam int REQ_SEL_W = log2up(NUM_REQS);

    logic [NUM_REQS-1:0]       in_valid;
    logic [NUM_REQS*DATAW-1:0] in_data;
    logic [NUM_REQS-1:0]       in_sop;
    logic [NUM_REQS-1:0]       in_eop;
    logic [NUM_REQS-1:0]       in_ready;

    logic                      out_valid;
    logic [DATAW-1:0]          out_data;
    logic                      out_sop;
    logic                      out_eop;
    logic [REQ_SEL_W-1:0]      out_sel;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_sel
    );

endinterface

// File: rtl/vx_dispatch_skid_buf.sv
// Two-entry full-throughput buffer: a push in cycle t is visible at the output in t+1.
// in_ready depends only on occupancy (never on out_ready); head entry holds still while stalled.
module vx_dispatch_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    logic [WIDTH-1:0] entry_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = entry_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) entry_q[wr_ptr_q] <= in_data;
    end

    stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/vx_dispatch_packet_arbiter.sv
// Round-robin packet arbiter sharing one FU port; locks on a requester from first beat to eop.
// One cycle from input fire to out_valid; in_ready drops only when the 2-entry buffer is full.
module vx_dispatch_packet_arbiter
    import vx_dispatch_packet_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int PERF_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    vx_dispatch_packet_arbiter_if.slave bus,
    output logic [PERF_W-1:0]           perf_stalls,
    output logic [PERF_W-1:0]           perf_packets
);
    localparam int REQ_SEL_W = log2up(NUM_REQS);

    // Beat layout follows the module parameters, so it is declared here.
    typedef struct packed {
        logic [REQ_SEL_W-1:0] sel;
        logic                 sop;
        logic                 eop;
        logic [DATAW-1:0]     data;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    arb_state_e           state_q, state_d;
    logic [REQ_SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic [REQ_SEL_W-1:0] grant_idx;
    logic [REQ_SEL_W-1:0] fire_idx;
    logic [NUM_REQS-1:0]  rot_valid;
    logic [NUM_REQS-1:0]  in_ready_c;
    logic                 buf_ready;
    logic                 accept_ok;
    logic                 in_fire;
    logic                 fire_eop;
    beat_t                buf_in;
    beat_t                buf_out;

    function automatic logic [REQ_SEL_W-1:0] find_first(input logic [NUM_REQS-1:0] v);
        logic [REQ_SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (v[i]) idx = REQ_SEL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [REQ_SEL_W-1:0] next_idx(input logic [REQ_SEL_W-1:0] i);
        return (i == REQ_SEL_W'(NUM_REQS - 1)) ? '0 : i + REQ_SEL_W'(1);
    endfunction

    // Rotate so rr_ptr sits at bit 0, find-first, then map back to the real index.
    always_comb begin
        int j;
        int g;
        for (int i = 0; i < NUM_REQS; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            rot_valid[i] = bus.in_valid[j];
        end
        g = int'(rr_ptr_q) + int'(find_first(rot_valid));
        if (g >= NUM_REQS) g = g - NUM_REQS;
        grant_idx = REQ_SEL_W'(g);
    end

    assign accept_ok = buf_ready & ~reset;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        in_ready_c = '0;
        fire_idx   = grant_idx;
        in_fire    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                fire_idx = grant_idx;
                if (|bus.in_valid) begin
                    in_ready_c[grant_idx] = accept_ok;
                    in_fire               = accept_ok;
                end
            end
            ARB_LOCKED: begin
                fire_idx               = lock_idx_q;
                in_ready_c[lock_idx_q] = accept_ok;
                in_fire                = accept_ok & bus.in_valid[lock_idx_q];
            end
            default: ;
        endcase
        fire_eop = bus.in_eop[fire_idx];
        if (in_fire) begin
            if (fire_eop) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = next_idx(fire_idx);
            end else begin
                state_d    = ARB_LOCKED;
                lock_idx_d = fire_idx;
            end
        end
    end

    assign bus.in_ready = in_ready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            perf_stalls  <= '0;
            perf_packets <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            if ((|bus.in_valid) && !in_fire) perf_stalls <= perf_stalls + PERF_W'(1);
            if (in_fire && fire_eop)         perf_packets <= perf_packets + PERF_W'(1);
        end
    end

    always_comb begin
        buf_in.sel  = fire_idx;
        buf_in.sop  = bus.in_sop[fire_idx];
        buf_in.eop  = fire_eop;
        buf_in.data = bus.in_data[int'(fire_idx) * DATAW +: DATAW];
    end

    vx_dispatch_skid_buf #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_fire),
        .in_data   (buf_in),
        .in_ready  (buf_ready),
        .out_valid (bus.out_valid),
        .out_data  (buf_out),
        .out_ready (bus.out_ready)
    );

    assign bus.out_data = buf_out.data;
    assign bus.out_sop  = buf_out.sop;
    assign bus.out_eop  = buf_out.eop;
    assign bus.out_sel  = buf_out.sel;

    ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.in_ready));

endmodule
